// File: rtl/fluxo_dados_param_pkg.sv
// Shared constants for the Genius-game datapath: configuration bit indices,
// LFSR polynomial/seed and score width.
package fluxo_dados_param_pkg;

  localparam int unsigned CFG_MODO      = 0;
  localparam int unsigned CFG_TIMEOUT   = 1;
  localparam int unsigned CFG_ALEATORIO = 2;

  // Galois right-shift mask for taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  localparam int unsigned SCORE_W = 8;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear; fim_o flags the last count while enabled.
module contador_m #(
  parameter int unsigned M = 100,
  parameter int unsigned N = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         zera_s_i,
  input  logic         enable_i,
  output logic [N-1:0] q_o,
  output logic         fim_o
);

  localparam logic [N-1:0] QMax = N'(M - 1);

  logic [N-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (zera_s_i) begin
      q_d = '0;
    end else if (enable_i) begin
      q_d = (q_q == QMax) ? '0 : q_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o   = q_q;
  assign fim_o = (q_q == QMax) && enable_i;

endmodule

// File: rtl/lfsr_16.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it out of the all-zero state.
module lfsr_16
  import fluxo_dados_param_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] state_o
);

  logic [15:0] state_d, state_q;

  always_comb state_d = lfsr_next(state_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/fluxo_dados_param.sv
// Genius-game datapath: sequence RAM, address/limit counters, player register,
// timers, lives and score, all driven cycle-by-cycle by the control unit.
module fluxo_dados_param
  import fluxo_dados_param_pkg::*;
#(
  parameter int unsigned NB             = 4,
  parameter int unsigned AW             = 4,
  parameter int unsigned DEMO_RODADAS   = 4,
  parameter int unsigned TIMEOUT_CICLOS = 5000,
  parameter int unsigned LED_CICLOS     = 2000,
  parameter int unsigned VIDAS          = 3,
  parameter logic [15:0] SEMENTE        = LFSR_SEED
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               zera_endereco,
  input  logic               conta_endereco,
  input  logic               zera_limite,
  input  logic               conta_limite,
  input  logic               zeraR,
  input  logic               registrarR,
  input  logic               zera_s_timeout,
  input  logic               enable_timeout,
  input  logic               zera_s_led,
  input  logic               enable_led,
  input  logic               registra_modo,
  input  logic               zera_modo,
  input  logic               gera_jogada,
  input  logic               registra_jogada,
  input  logic               conta_acerto,
  input  logic               perde_vida,
  input  logic               conf_leds,
  input  logic [NB-1:0]      botoes,
  input  logic [2:0]         configuracao,
  output logic               igual,
  output logic               fim_jogo,
  output logic               enderecoIgualLimite,
  output logic               fim_sequencia,
  output logic               jogada_feita,
  output logic               jogada_valida,
  output logic               timeout,
  output logic               timeout_led,
  output logic               timeout_habilitado,
  output logic               aleatorio,
  output logic               sem_vidas,
  output logic [NB-1:0]      led,
  output logic [SCORE_W-1:0] pontuacao,
  output logic [2:0]         vidas,
  output logic [AW-1:0]      db_contagem,
  output logic [AW-1:0]      db_limite,
  output logic [NB-1:0]      db_memoria,
  output logic [NB-1:0]      db_jogada,
  output logic               db_modo,
  output logic               db_tem_jogada
);

  localparam logic [AW-1:0]      LimNormal = '1;
  localparam logic [AW-1:0]      LimDemo   = AW'(DEMO_RODADAS - 1);
  localparam logic [2:0]         VidasIni  = 3'(VIDAS);
  localparam logic [SCORE_W-1:0] ScoreMax  = '1;

  logic [AW-1:0]      endereco_d, endereco_q;
  logic [AW-1:0]      limite_d, limite_q;
  logic [NB-1:0]      jogada_d, jogada_q;
  logic [2:0]         cfg_d, cfg_q;
  logic               prev_d, prev_q;
  logic [2:0]         vidas_d, vidas_q;
  logic [SCORE_W-1:0] score_d, score_q;

  logic [NB-1:0] mem_q [2**AW];
  logic [NB-1:0] mem_rd;

  logic [15:0]   lfsr;
  logic [7:0]    cor_idx;
  logic [NB-1:0] cor_lfsr;
  logic          unused_lfsr;

  logic [((TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1)-1:0] unused_tmo_q;
  logic [((LED_CICLOS > 1) ? $clog2(LED_CICLOS) : 1)-1:0]         unused_led_q;

  lfsr_16 #(
    .SEED (SEMENTE)
  ) u_lfsr (
    .clk_i   (clock),
    .rst_i   (reset),
    .state_o (lfsr)
  );

  contador_m #(
    .M (TIMEOUT_CICLOS)
  ) u_timer_timeout (
    .clk_i    (clock),
    .rst_i    (reset),
    .zera_s_i (zera_s_timeout),
    .enable_i (enable_timeout),
    .q_o      (unused_tmo_q),
    .fim_o    (timeout)
  );

  contador_m #(
    .M (LED_CICLOS)
  ) u_timer_led (
    .clk_i    (clock),
    .rst_i    (reset),
    .zera_s_i (zera_s_led),
    .enable_i (enable_led),
    .q_o      (unused_led_q),
    .fim_o    (timeout_led)
  );

  assign cor_idx     = lfsr[7:0] % 8'(NB);
  assign cor_lfsr    = NB'(1) << cor_idx;
  assign unused_lfsr = ^lfsr[15:8];

  always_comb begin
    endereco_d = endereco_q;
    limite_d   = limite_q;
    jogada_d   = jogada_q;
    cfg_d      = cfg_q;
    vidas_d    = vidas_q;
    score_d    = score_q;
    prev_d     = |botoes;

    if (zera_endereco)       endereco_d = '0;
    else if (conta_endereco) endereco_d = endereco_q + 1'b1;

    if (zera_limite)       limite_d = '0;
    else if (conta_limite) limite_d = limite_q + 1'b1;

    if (zeraR)           jogada_d = '0;
    else if (registrarR) jogada_d = botoes;

    if (zera_modo)          cfg_d = '0;
    else if (registra_modo) cfg_d = configuracao;

    if (zera_modo)                         vidas_d = VidasIni;
    else if (perde_vida && vidas_q != '0)  vidas_d = vidas_q - 1'b1;

    if (zera_modo)                             score_d = '0;
    else if (conta_acerto && score_q != ScoreMax) score_d = score_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      endereco_q <= '0;
      limite_q   <= '0;
      jogada_q   <= '0;
      cfg_q      <= '0;
      prev_q     <= 1'b1;
      vidas_q    <= VidasIni;
      score_q    <= '0;
    end else begin
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      jogada_q   <= jogada_d;
      cfg_q      <= cfg_d;
      prev_q     <= prev_d;
      vidas_q    <= vidas_d;
      score_q    <= score_d;
    end
  end

  // Sequence RAM is deliberately outside reset so a game can be replayed.
  always_ff @(posedge clock) begin
    if (gera_jogada)          mem_q[endereco_q] <= cor_lfsr;
    else if (registra_jogada) mem_q[endereco_q] <= botoes;
  end

  assign mem_rd = mem_q[endereco_q];

  assign igual               = (mem_rd == jogada_q);
  assign fim_jogo            = (limite_q == (cfg_q[CFG_MODO] ? LimDemo : LimNormal));
  assign enderecoIgualLimite = (endereco_q == limite_q);
  assign fim_sequencia       = (endereco_q == limite_q);
  assign jogada_valida       = $onehot(botoes);
  assign db_tem_jogada       = |botoes;
  assign jogada_feita        = (|botoes) & ~prev_q;
  assign timeout_habilitado  = cfg_q[CFG_TIMEOUT];
  assign aleatorio           = cfg_q[CFG_ALEATORIO];
  assign db_modo             = cfg_q[CFG_MODO];
  assign sem_vidas           = (vidas_q == '0);
  assign led                 = conf_leds ? mem_rd : '0;
  assign pontuacao           = score_q;
  assign vidas               = vidas_q;
  assign db_contagem         = endereco_q;
  assign db_limite           = limite_q;
  assign db_memoria          = mem_rd;
  assign db_jogada           = jogada_q;

endmodule

// File: tb/tb_fluxo_dados_param.sv
// Directed bench for fluxo_dados_param with NB=4, AW=4, short timers.
module tb_fluxo_dados_param;

  logic clock = 1'b0;
  logic reset;
  logic zera_endereco, conta_endereco, zera_limite, conta_limite;
  logic zeraR, registrarR;
  logic zera_s_timeout, enable_timeout, zera_s_led, enable_led;
  logic registra_modo, zera_modo, gera_jogada, registra_jogada;
  logic conta_acerto, perde_vida, conf_leds;
  logic [3:0] botoes;
  logic [2:0] configuracao;
  logic igual, fim_jogo, enderecoIgualLimite, fim_sequencia;
  logic jogada_feita, jogada_valida, timeout, timeout_led;
  logic timeout_habilitado, aleatorio, sem_vidas;
  logic [3:0] led, db_memoria, db_jogada, db_contagem, db_limite;
  logic [7:0] pontuacao;
  logic [2:0] vidas;
  logic db_modo, db_tem_jogada;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  exp_mem [16];

  always #5 clock = ~clock;

  fluxo_dados_param #(
    .NB(4), .AW(4), .DEMO_RODADAS(4), .TIMEOUT_CICLOS(5), .LED_CICLOS(3),
    .VIDAS(3), .SEMENTE(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset),
    .zera_endereco(zera_endereco), .conta_endereco(conta_endereco),
    .zera_limite(zera_limite), .conta_limite(conta_limite),
    .zeraR(zeraR), .registrarR(registrarR),
    .zera_s_timeout(zera_s_timeout), .enable_timeout(enable_timeout),
    .zera_s_led(zera_s_led), .enable_led(enable_led),
    .registra_modo(registra_modo), .zera_modo(zera_modo),
    .gera_jogada(gera_jogada), .registra_jogada(registra_jogada),
    .conta_acerto(conta_acerto), .perde_vida(perde_vida), .conf_leds(conf_leds),
    .botoes(botoes), .configuracao(configuracao),
    .igual(igual), .fim_jogo(fim_jogo), .enderecoIgualLimite(enderecoIgualLimite),
    .fim_sequencia(fim_sequencia), .jogada_feita(jogada_feita),
    .jogada_valida(jogada_valida), .timeout(timeout), .timeout_led(timeout_led),
    .timeout_habilitado(timeout_habilitado), .aleatorio(aleatorio),
    .sem_vidas(sem_vidas), .led(led), .pontuacao(pontuacao), .vidas(vidas),
    .db_contagem(db_contagem), .db_limite(db_limite), .db_memoria(db_memoria),
    .db_jogada(db_jogada), .db_modo(db_modo), .db_tem_jogada(db_tem_jogada)
  );

  // Reference Galois LFSR, taps 16,14,13,11, written from the polynomial.
  function automatic logic [15:0] galois(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[15] = n[15] ^ 1'b1;
      n[13] = n[13] ^ 1'b1;
      n[12] = n[12] ^ 1'b1;
      n[10] = n[10] ^ 1'b1;
    end
    return n;
  endfunction

  always @(posedge clock) m_lfsr <= reset ? 16'hACE1 : galois(m_lfsr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] lo;
    {zera_endereco, conta_endereco, zera_limite, conta_limite} = '0;
    {zeraR, registrarR, zera_s_timeout, enable_timeout, zera_s_led, enable_led} = '0;
    {registra_modo, zera_modo, gera_jogada, registra_jogada} = '0;
    {conta_acerto, perde_vida, conf_leds} = '0;
    configuracao = 3'b000;

    // Reset with a button held throughout
    reset = 1'b1; botoes = 4'b0010;
    tick; tick;
    reset = 1'b0;
    #1;
    check("rst_vidas", vidas, 3);
    check("rst_pontuacao", pontuacao, 0);
    check("rst_led", led, 0);
    check("rst_contagem", db_contagem, 0);
    check("rst_timeout", timeout, 0);
    check("rst_sem_vidas", sem_vidas, 0);
    check("rst_held_no_pulse", jogada_feita, 0);
    tick;
    check("held_no_pulse", jogada_feita, 0);
    botoes = 4'b0000; tick;
    botoes = 4'b0001; #1;
    check("press_pulse", jogada_feita, 1);
    check("valida_onehot", jogada_valida, 1);
    tick;
    check("held_single_pulse", jogada_feita, 0);
    botoes = 4'b0011; #1;
    check("valida_two_bits", jogada_valida, 0);
    check("tem_jogada", db_tem_jogada, 1);
    botoes = 4'b0000;

    // Demo-mode limit and counter wrap
    configuracao = 3'b001; registra_modo = 1; zera_limite = 1; zera_endereco = 1;
    tick;
    registra_modo = 0; zera_limite = 0; zera_endereco = 0;
    check("modo_demo", db_modo, 1);
    check("end_eq_lim_zero", enderecoIgualLimite, 1);
    conta_limite = 1;
    tick; tick;
    check("demo_lim2_no_fim", fim_jogo, 0);
    tick;
    conta_limite = 0;
    check("demo_limite3", db_limite, 3);
    check("demo_fim_jogo", fim_jogo, 1);
    check("fim_seq_off", fim_sequencia, 0);
    configuracao = 3'b110; registra_modo = 1;
    tick;
    registra_modo = 0;
    check("normal_lim3_no_fim", fim_jogo, 0);
    check("cfg_timeout_hab", timeout_habilitado, 1);
    check("cfg_aleatorio", aleatorio, 1);
    conta_limite = 1;
    repeat (12) tick;
    check("normal_limite15", db_limite, 15);
    check("normal_fim_jogo", fim_jogo, 1);
    tick;
    conta_limite = 0;
    check("limite_wrap", db_limite, 0);
    conta_endereco = 1; zera_endereco = 1;
    tick;
    conta_endereco = 0; zera_endereco = 0;
    check("zera_over_conta", db_contagem, 0);

    // RAM write, player register and LED gating
    conta_endereco = 1; tick; tick; conta_endereco = 0;
    botoes = 4'b0100; registra_jogada = 1;
    tick;
    registra_jogada = 0;
    check("igual_before_reg", igual, 0);
    registrarR = 1;
    tick;
    registrarR = 0;
    check("igual_after_reg", igual, 1);
    check("db_jogada", db_jogada, 4'b0100);
    check("db_memoria_addr2", db_memoria, 4'b0100);
    check("led_off", led, 0);
    conf_leds = 1; #1;
    check("led_on", led, 4'b0100);
    conf_leds = 0;
    zeraR = 1; registrarR = 1;
    tick;
    zeraR = 0; registrarR = 0;
    check("zeraR_priority", db_jogada, 0);
    botoes = 4'b0000;

    // LFSR colour generation, overriding a simultaneous botoes write
    zera_endereco = 1; tick; zera_endereco = 0;
    for (int i = 0; i < 16; i++) begin
      gera_jogada = 1; registra_jogada = 1; conta_endereco = 1; botoes = 4'b1111;
      lo = m_lfsr[7:0];
      exp_mem[i] = 4'b0001 << (lo % 8'd4);
      tick;
    end
    gera_jogada = 0; registra_jogada = 0; conta_endereco = 0; botoes = 4'b0000;
    zera_endereco = 1; tick; zera_endereco = 0;
    conta_endereco = 1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("gera_word%0d", i), db_memoria, exp_mem[i]);
      check($sformatf("gera_onehot%0d", i), $countones(db_memoria), 1);
      tick;
    end
    conta_endereco = 0;

    // Timeout timer: fires on 5th enabled cycle, holds when paused
    zera_s_timeout = 1; tick; zera_s_timeout = 0;
    enable_timeout = 1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check($sformatf("timeout_cyc%0d", i), timeout, (i == 5));
      tick;
    end
    check("timeout_wrap", timeout, 0);
    zera_s_timeout = 1; tick; zera_s_timeout = 0;
    repeat (3) tick;
    enable_timeout = 0;
    repeat (2) tick;
    enable_timeout = 1; #1;
    check("timeout_paused_q3", timeout, 0);
    tick;
    check("timeout_resumed_q4", timeout, 1);
    zera_s_timeout = 1; tick; zera_s_timeout = 0;
    check("timeout_restart", timeout, 0);
    enable_timeout = 0;
    zera_s_led = 1; tick; zera_s_led = 0;
    enable_led = 1; #1;
    check("timeout_led_cyc1", timeout_led, 0);
    tick; tick;
    check("timeout_led_cyc3", timeout_led, 1);
    enable_led = 0;

    // Lives and score
    perde_vida = 1;
    tick;
    check("vidas_2", vidas, 2);
    tick; tick;
    check("vidas_0", vidas, 0);
    check("sem_vidas", sem_vidas, 1);
    tick;
    perde_vida = 0;
    check("vidas_hold0", vidas, 0);
    conta_acerto = 1;
    repeat (300) tick;
    conta_acerto = 0;
    check("score_sat", pontuacao, 255);
    zera_modo = 1; perde_vida = 1; conta_acerto = 1;
    tick;
    zera_modo = 0; perde_vida = 0; conta_acerto = 0;
    check("zera_modo_vidas", vidas, 3);
    check("zera_modo_score", pontuacao, 0);
    check("zera_modo_sem_vidas", sem_vidas, 0);

    // Reset mid-game keeps RAM
    conta_limite = 1; conta_acerto = 1; zera_endereco = 1;
    tick; tick;
    conta_limite = 0; conta_acerto = 0; zera_endereco = 0;
    reset = 1; tick; reset = 0;
    check("midrst_limite", db_limite, 0);
    check("midrst_score", pontuacao, 0);
    check("midrst_modo", db_modo, 0);
    check("midrst_ram_kept", db_memoria, exp_mem[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
